// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache block refill logic.
//   fill_state_t      - refill FSM state encoding (IDLE, FILL)
//   WORDS_PER_BLOCK   - default number of 16-bit words per cache block
//   BLOCK_OFFSET_BITS - byte-offset bits inside one block
//   block_base_mask   - mask that clears the block byte offset of an address
package cache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = $clog2(2 * WORDS_PER_BLOCK);

  // Returned 64 bits wide so any address width can take its low slice.
  function automatic logic [63:0] block_base_mask(input int unsigned off_bits);
    return ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: saturating up-counter with synchronous clear and enable.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   clr   in   synchronous clear (same effect as rst)
//   en    in   count enable; ignored once the count has reached MAX
//   cnt   out  current count
//   tc    out  terminal count, high while cnt == MAX
module fill_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == MAX_CNT);

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: refills one cache block from 16-bit-wide backing memory.
// On a miss it issues WORDS_PER_BLOCK sequential word reads (one per cycle),
// steers each returned word into the data array, writes the tag with the
// last word and stalls the pipeline while the refill is in progress.
//   clk               in   clock
//   rst               in   synchronous active-high reset
//   miss_detected     in   cache lookup missed this cycle
//   miss_address      in   byte address that missed
//   memory_data_valid in   memory returns a read word this cycle
//   fsm_busy          out  stall request to the pipeline
//   mem_en            out  read request to memory
//   memory_address    out  word-aligned read address
//   write_data_array  out  write the returned word into the data array
//   fill_word_idx     out  word slot for that write
//   write_tag_array   out  one-cycle tag/valid write on the last word
//
// state | meaning
// IDLE  | no refill; stall follows miss_detected, a miss captures the base
// FILL  | issuing reads and collecting returned words until the last word
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_en,
  output logic [ADDR_WIDTH-1:0]              memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
  output logic                               write_tag_array
);

  import cache_pkg::*;

  localparam int IDX_W    = $clog2(WORDS_PER_BLOCK);
  // Issue counter must reach WORDS_PER_BLOCK itself to mark "all issued".
  localparam int ISSUE_W  = $clog2(WORDS_PER_BLOCK + 1);
  localparam int OFF_BITS = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [63:0]           MASK_FULL = block_base_mask(OFF_BITS);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = MASK_FULL[ADDR_WIDTH-1:0];

  fill_state_t           state_q;
  fill_state_t           state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ISSUE_W-1:0]    issue_cnt;
  logic                  issue_tc;
  logic [IDX_W-1:0]      recv_cnt;
  logic                  recv_tc;
  logic                  miss_accept;
  logic                  in_fill;

  assign in_fill     = (state_q == FILL);
  assign miss_accept = (state_q == IDLE) && miss_detected;

  // State register and block base capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss_accept) begin
        base_q <= miss_address & BASE_MASK;
      end
    end
  end

  fill_counter #(
    .WIDTH (ISSUE_W),
    .MAX   (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (miss_accept),
    .en  (in_fill && !issue_tc),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  // Receive counter tops out at the last slot; the FSM leaves FILL on it.
  fill_counter #(
    .WIDTH (IDX_W),
    .MAX   (WORDS_PER_BLOCK - 1)
  ) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (miss_accept),
    .en  (in_fill && memory_data_valid),
    .cnt (recv_cnt),
    .tc  (recv_tc)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (miss_detected) state_d = FILL;
      FILL: if (memory_data_valid && recv_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is held at 0 while rst is asserted so a
  // reset mid-refill can never produce a partial array or tag write.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_idx    = '0;
    write_tag_array  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: fsm_busy = miss_detected;
        FILL: begin
          fsm_busy         = 1'b1;
          mem_en           = !issue_tc;
          memory_address   = base_q + ADDR_WIDTH'({issue_cnt, 1'b0});
          write_data_array = memory_data_valid;
          fill_word_idx    = recv_cnt;
          write_tag_array  = memory_data_valid && recv_tc;
        end
        default: fsm_busy = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word_idx;
  logic        write_tag_array;

  int checks;
  int errors;
  int tag_total;

  cache_fill_fsm #(
    .ADDR_WIDTH      (16),
    .WORDS_PER_BLOCK (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_idx     (fill_word_idx),
    .write_tag_array   (write_tag_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        miss;
    logic [15:0] addr;
    logic        valid;
    logic        busy;
    logic        men;
    logic        chka;
    logic [15:0] eaddr;
    logic        wda;
    logic [2:0]  idx;
    logic        tag;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic m, input logic [15:0] a, input logic v,
                         input logic b, input logic me, input logic ca, input logic [15:0] ea,
                         input logic w, input logic [2:0] ix, input logic t);
    vec_t e;
    e.rst = r; e.miss = m; e.addr = a; e.valid = v;
    e.busy = b; e.men = me; e.chka = ca; e.eaddr = ea;
    e.wda = w; e.idx = ix; e.tag = t;
    vecs.push_back(e);
  endtask

  // One refill with a FIFO memory model of latency lat. Cycle 0 is the miss
  // cycle. Optional gap stalls returns after word 4; optional remiss raises a
  // second miss (0x4000) at cycle 3. Returns the cycle of the tag pulse.
  task automatic run_fill(input logic [15:0] a, input int lat, input int gap,
                          input bit remiss, output int tag_c, output logic [15:0] last_addr);
    int arr[$];
    int issued;
    int recvd;
    int hold;
    bit done;
    bit v;
    bit exp_men;
    logic [15:0] base;
    logic [2:0] ridx;
    issued = 0; recvd = 0; hold = 0; done = 0; tag_c = -1;
    last_addr = 16'h0;
    base = a & 16'hFFF0;
    for (int c = 0; c < 60 && !done; c++) begin
      rst = 1'b0;
      miss_detected = (c == 0) || (remiss && c == 3);
      miss_address = (c == 0) ? a : 16'h4000;
      v = (arr.size() > 0) && (c >= 1) && (c >= hold) && (arr[0] <= c);
      memory_data_valid = v;
      #4;
      exp_men = (c >= 1) && (issued < 8);
      ridx = recvd[2:0];
      chk("busy", {31'd0, fsm_busy}, 32'd1);
      chk("mem_en", {31'd0, mem_en}, {31'd0, exp_men});
      if (exp_men) begin
        chk("addr", {16'd0, memory_address}, {16'd0, base + 16'(2 * issued)});
        last_addr = memory_address;
        arr.push_back(c + lat);
        issued++;
      end
      chk("wda", {31'd0, write_data_array}, {31'd0, v});
      if (v) chk("idx", {29'd0, fill_word_idx}, {29'd0, ridx});
      chk("tag", {31'd0, write_tag_array}, {31'd0, v && (recvd == 7)});
      if (write_tag_array) tag_total++;
      if (v) begin
        void'(arr.pop_front());
        if (recvd == 4 && gap > 0) hold = c + 1 + gap;
        if (recvd == 7) begin
          done = 1;
          tag_c = c;
        end
        recvd++;
      end
      next_cycle();
    end
    if (!done) chk("fill_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_check(input string name, input logic v);
    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0; memory_data_valid = v;
    #4;
    chk({name, "_busy"}, {31'd0, fsm_busy}, 32'd0);
    chk({name, "_wda"}, {31'd0, write_data_array}, 32'd0);
    chk({name, "_tag"}, {31'd0, write_tag_array}, 32'd0);
    chk({name, "_men"}, {31'd0, mem_en}, 32'd0);
    next_cycle();
  endtask

  initial begin
    int tc1;
    int tc2;
    int tags_before;
    logic [15:0] la;
    checks = 0; errors = 0; tag_total = 0;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0; memory_data_valid = 1'b0;

    // Basic refill, miss 0x1236, latency 4; cycle 0 is the miss cycle.
    add_vec(1, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 3'd0, 0);
    add_vec(0, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 3'd0, 0);
    add_vec(0, 1, 16'h1236, 0,  1, 0, 1, 16'h0000, 0, 3'd0, 0);
    for (int c = 1; c <= 12; c++) begin
      add_vec(0, 0, 16'h0000, (c >= 5),
              1, (c <= 8), (c <= 8), 16'h1230 + 16'(2 * (c - 1)),
              (c >= 5), (c >= 5) ? 3'(c - 5) : 3'd0, (c == 12));
    end
    add_vec(0, 0, 16'h0000, 0,  0, 0, 1, 16'h0000, 0, 3'd0, 0);

    next_cycle();
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      miss_detected = vecs[i].miss;
      miss_address = vecs[i].addr;
      memory_data_valid = vecs[i].valid;
      #4;
      chk($sformatf("v%0d_busy", i), {31'd0, fsm_busy}, {31'd0, vecs[i].busy});
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].men});
      if (vecs[i].chka)
        chk($sformatf("v%0d_addr", i), {16'd0, memory_address}, {16'd0, vecs[i].eaddr});
      chk($sformatf("v%0d_wda", i), {31'd0, write_data_array}, {31'd0, vecs[i].wda});
      chk($sformatf("v%0d_idx", i), {29'd0, fill_word_idx}, {29'd0, vecs[i].idx});
      chk($sformatf("v%0d_tag", i), {31'd0, write_tag_array}, {31'd0, vecs[i].tag});
      next_cycle();
    end

    // Top-of-memory block: base 0xFFF0, last address 0xFFFE without wrap.
    run_fill(16'hFFFE, 4, 0, 0, tc1, la);
    chk("wrap_tag_cycle", tc1, 32'd12);
    chk("wrap_last_addr", {16'd0, la}, 32'h0000FFFE);
    idle_check("wrap_after", 1'b0);

    // Miss during FILL ignored: one tag pulse, addresses stay in first block.
    tags_before = tag_total;
    run_fill(16'h1236, 4, 0, 1, tc1, la);
    idle_check("remiss_after0", 1'b1);
    idle_check("remiss_after1", 1'b0);
    chk("remiss_tag_count", tag_total - tags_before, 32'd1);
    chk("remiss_tag_cycle", tc1, 32'd12);

    // Reset after three words received (latency 2, returns at cycles 3..5).
    for (int c = 0; c <= 5; c++) begin
      rst = 1'b0;
      miss_detected = (c == 0);
      miss_address = 16'h2000;
      memory_data_valid = (c >= 3);
      #4;
      if (c == 5) begin
        chk("rst_pre_wda", {31'd0, write_data_array}, 32'd1);
        chk("rst_pre_idx", {29'd0, fill_word_idx}, 32'd2);
        chk("rst_pre_tag", {31'd0, write_tag_array}, 32'd0);
      end
      next_cycle();
    end
    rst = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b1;
    #4;
    chk("rst_cyc_busy", {31'd0, fsm_busy}, 32'd0);
    chk("rst_cyc_wda", {31'd0, write_data_array}, 32'd0);
    chk("rst_cyc_tag", {31'd0, write_tag_array}, 32'd0);
    next_cycle();
    idle_check("rst_stray0", 1'b1);
    idle_check("rst_stray1", 1'b1);
    run_fill(16'h2000, 2, 0, 0, tc1, la);
    chk("rst_refill_tag_cycle", tc1, 32'd10);

    // Back-to-back misses with latency 1.
    tags_before = tag_total;
    run_fill(16'h0100, 1, 0, 0, tc1, la);
    run_fill(16'h0124, 1, 0, 0, tc2, la);
    chk("b2b_tag_cycle1", tc1, 32'd9);
    chk("b2b_tag_cycle2", tc2, 32'd9);
    chk("b2b_tag_count", tag_total - tags_before, 32'd2);
    chk("b2b_last_addr", {16'd0, la}, 32'h0000012E);
    idle_check("b2b_after", 1'b0);

    // Gapped returns: 3 stalled cycles after word 4 delay completion by 3.
    run_fill(16'h3458, 4, 3, 0, tc1, la);
    chk("gap_tag_cycle", tc1, 32'd15);
    idle_check("gap_after", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
